// File: rtl/trace_packetizer_if.sv
// trace_packetizer_if: upstream request/capture and downstream byte-stream signals of the trace packetizer
interface trace_packetizer_if #(
    parameter int TRACE_WIDTH = 64
);
    logic                   data_present;
    logic                   data_valid;
    logic [TRACE_WIDTH-1:0] trace_element_in;
    logic [31:0]            if_stage_end_in;
    logic                   data_request;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic [7:0]             timeout_count;

    modport master (
        output data_present, data_valid, trace_element_in, if_stage_end_in, out_ready,
        input  data_request, out_data, out_valid, busy, timeout_count
    );

    modport slave (
        input  data_present, data_valid, trace_element_in, if_stage_end_in, out_ready,
        output data_request, out_data, out_valid, busy, timeout_count
    );
endinterface

// File: rtl/trace_packetizer.sv
// trace_packetizer: fetches one trace element and serialises header, element, timestamp (and an XOR checksum when TRACE_PKT_CHECKSUM_EN is defined) as bytes
module trace_packetizer #(
    parameter int         TRACE_WIDTH    = 64,
    parameter logic [7:0] HEADER_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 8
) (
    input logic             clk,
    input logic             rst,
    trace_packetizer_if.slave bus
);
`ifdef TRACE_PKT_CHECKSUM_EN
    localparam int NB = TRACE_WIDTH / 8 + 6;
`else
    localparam int NB = TRACE_WIDTH / 8 + 5;
`endif
    localparam int LP = TRACE_WIDTH / 8 + 4;
    localparam int IW = $clog2(NB);
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VALID,
        SEND_HDR,
        SEND_PAYLOAD
`ifdef TRACE_PKT_CHECKSUM_EN
        , SEND_CSUM
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic [7:0]             tcnt_q, tcnt_d;
    logic [TRACE_WIDTH-1:0] elem_q, elem_d;
    logic [31:0]            end_q, end_d;
    logic [NB*8-1:0]        pkt, pkt_sh;
    logic                   out_valid, xfer;
`ifdef TRACE_PKT_CHECKSUM_EN
    logic [7:0]             csum_q, csum_d;
    assign pkt = {csum_q, end_q, elem_q, HEADER_BYTE};
`else
    assign pkt = {end_q, elem_q, HEADER_BYTE};
`endif

    assign out_valid         = state_q != IDLE && state_q != WAIT_VALID;
    assign xfer              = out_valid && bus.out_ready;
    assign pkt_sh            = pkt >> {idx_q, 3'b000};
    assign bus.out_data      = out_valid ? pkt_sh[7:0] : 8'h00;
    assign bus.out_valid     = out_valid;
    assign bus.data_request  = req_q;
    assign bus.busy          = state_q != IDLE;
    assign bus.timeout_count = tcnt_q;

    // next state, request pulse, element capture, timeout accounting and byte sequencing
    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        idx_d   = idx_q;
        wait_d  = wait_q;
        tcnt_d  = tcnt_q;
        elem_d  = elem_q;
        end_d   = end_q;
`ifdef TRACE_PKT_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: if (bus.data_present) begin
                state_d = WAIT_VALID;
                req_d   = 1'b1;
                wait_d  = '0;
            end
            WAIT_VALID: if (bus.data_valid) begin
                state_d = SEND_HDR;
                elem_d  = bus.trace_element_in;
                end_d   = bus.if_stage_end_in;
                idx_d   = '0;
`ifdef TRACE_PKT_CHECKSUM_EN
                csum_d  = 8'h00;
`endif
            end else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                tcnt_d  = tcnt_q == 8'hFF ? tcnt_q : tcnt_q + 8'd1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
            SEND_HDR: if (xfer) begin
                state_d = SEND_PAYLOAD;
                idx_d   = idx_q + 1'b1;
            end
            SEND_PAYLOAD: if (xfer) begin
                idx_d = idx_q + 1'b1;
`ifdef TRACE_PKT_CHECKSUM_EN
                csum_d = csum_q ^ bus.out_data;
                if (idx_q == IW'(LP)) state_d = SEND_CSUM;
`else
                if (idx_q == IW'(LP)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
`endif
            end
`ifdef TRACE_PKT_CHECKSUM_EN
            SEND_CSUM: if (xfer) begin
                state_d = IDLE;
                idx_d   = '0;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            idx_q   <= '0;
            wait_q  <= '0;
            tcnt_q  <= 8'h00;
            elem_q  <= '0;
            end_q   <= 32'h0;
`ifdef TRACE_PKT_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            tcnt_q  <= tcnt_d;
            elem_q  <= elem_d;
            end_q   <= end_d;
`ifdef TRACE_PKT_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_trace_packetizer.sv
// tb_trace_packetizer: randomized scoreboard bench for trace_packetizer with directed backpressure, timeout, reset and spurious-pulse scenarios
module tb_trace_packetizer;
    localparam logic [7:0] HDR = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nfail = 0;
    int   req_cnt = 0;
    int   ready_mode = 0;
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    trace_packetizer_if #(.TRACE_WIDTH(64)) bus();

    trace_packetizer #(.TRACE_WIDTH(64), .HEADER_BYTE(HDR), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference packet: header, element bytes LSB first, timestamp bytes LSB first, optional XOR of payload
    task automatic push_pkt(input logic [63:0] e, input logic [31:0] t);
        logic [7:0] b;
        logic [7:0] cs;
        cs = 8'h00;
        exp_q.push_back(HDR);
        for (int i = 0; i < 8; i++) begin
            b = e[8*i +: 8];
            cs ^= b;
            exp_q.push_back(b);
        end
        for (int i = 0; i < 4; i++) begin
            b = t[8*i +: 8];
            cs ^= b;
            exp_q.push_back(b);
        end
`ifdef TRACE_PKT_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic wait_req(input int bound);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.data_request && n < bound);
        check("req_seen", bus.data_request, 1);
    endtask

    task automatic respond(input logic [63:0] e, input logic [31:0] t, input int delay);
        repeat (delay) tick();
        bus.data_valid = 1'b1;
        bus.trace_element_in = e;
        bus.if_stage_end_in = t;
        push_pkt(e, t);
        tick();
        bus.data_valid = 1'b0;
    endtask

    task automatic start_elem(input logic [63:0] e, input logic [31:0] t, input int delay);
        bus.data_present = 1'b1;
        wait_req(50);
        bus.data_present = 1'b0;
        respond(e, t, delay);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 2000) begin
            tick();
            n++;
        end
        check("drain", exp_q.size() == 0 && !bus.busy, 1);
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expected bytes on every transfer and checks stability under backpressure
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.data_request) req_cnt++;
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_byte", bus.out_data, 64'hX);
                else check("byte", bus.out_data, exp_q.pop_front());
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        bus.data_present = 1'b0;
        bus.data_valid = 1'b0;
        bus.trace_element_in = '0;
        bus.if_stage_end_in = '0;
        repeat (2) tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_req", bus.data_request, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_tcnt", bus.timeout_count, 0);
        rst = 1'b0;
        tick();

        // Basic packet with the reference vector
        start_elem(64'h0123456789ABCDEF, 32'h10, 0);
        drain();

        // Backpressure while byte index 5 (8'h67) is presented
        bus.data_present = 1'b1;
        wait_req(50);
        bus.data_present = 1'b0;
        respond(64'h0123456789ABCDEF, 32'h10, 2);
        n = 0;
        while (!(bus.out_valid && bus.out_data == 8'h67) && n < 40) begin
            tick();
            n++;
        end
        check("bp_found", bus.out_valid && bus.out_data == 8'h67, 1);
        ready_mode = 2;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", bus.out_valid, 1);
            check("bp_data", bus.out_data, 8'h67);
            tick();
        end
        ready_mode = 0;
        drain();

        // Spurious data_valid while idle
        bus.data_valid = 1'b1;
        bus.trace_element_in = 64'hDEADBEEFCAFEF00D;
        tick();
        bus.data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("spur_busy", bus.busy, 0);
            check("spur_valid", bus.out_valid, 0);
            tick();
        end

        // Timeout then retry
        bus.data_present = 1'b1;
        wait_req(50);
        repeat (7) tick();
        check("to_busy_before", bus.busy, 1);
        check("to_cnt_before", bus.timeout_count, 0);
        tick();
        check("to_idle", bus.busy, 0);
        check("to_cnt", bus.timeout_count, 1);
        tick();
        check("to_retry_req", bus.data_request, 1);
        bus.data_present = 1'b0;
        respond(64'h1122334455667788, 32'hA0B0C0D0, 1);
        drain();

        // Reset at byte index 3 (8'hAB)
        start_elem(64'h0123456789ABCDEF, 32'h10, 0);
        n = 0;
        while (!(bus.out_valid && bus.out_data == 8'hAB) && n < 40) begin
            tick();
            n++;
        end
        check("rst_found", bus.out_valid && bus.out_data == 8'hAB, 1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_tcnt", bus.timeout_count, 0);
        check("mid_rst_busy", bus.busy, 0);
        rst = 1'b0;
        start_elem(64'hFEDCBA9876543210, 32'h12345678, 3);
        drain();

        // Back-to-back elements: one request per packet
        r0 = req_cnt;
        bus.data_present = 1'b1;
        wait_req(50);
        respond(64'hA5A5A5A5A5A5A5A5, 32'h0000FFFF, 2);
        wait_req(200);
        bus.data_present = 1'b0;
        respond(64'h0F0F0F0F0F0F0F0F, 32'hFFFF0000, 0);
        drain();
        repeat (3) tick();
        check("b2b_req_count", req_cnt - r0, 2);

        // Randomized packets under random backpressure
        ready_mode = 1;
        for (int k = 0; k < 25; k++) begin
            start_elem({$urandom, $urandom}, $urandom, $urandom_range(0, 5));
            drain();
        end
        ready_mode = 0;
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/trace_packetizer.md
TRACE_PACKETIZER -- requirements
Module: trace_packetizer

Interface
REQ-001 SHALL have parameter TRACE_WIDTH, default 64: trace element width in bits; a multiple of 8 and at least 8.
REQ-002 SHALL have parameter HEADER_BYTE, default 8'hA5: first byte of every packet.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 8: cycles to wait for data_valid after a request; at least 3.
REQ-004 SHALL use one clock and a synchronous active-high reset; all state SHALL be updated on the rising edge of clk.
REQ-005 port: clk  input  1  system clock.
REQ-006 port: rst  input  1  synchronous, active-high reset.
REQ-007 port: data_present  input  1  upstream buffer holds at least one element.
REQ-008 port: data_valid  input  1  one-cycle pulse; upstream element outputs are valid this cycle.
REQ-009 port: trace_element_in  input  TRACE_WIDTH  upstream trace element.
REQ-010 port: if_stage_end_in  input  32  upstream IF-stage end timestamp.
REQ-011 port: data_request  output  1  registered one-cycle pulse requesting one element.
REQ-012 port: out_data  output  8  serial packet byte.
REQ-013 port: out_valid  output  1  out_data is valid.
REQ-014 port: out_ready  input  1  downstream accepts the byte.
REQ-015 port: busy  output  1  high whenever the state is not IDLE.
REQ-016 port: timeout_count  output  8  saturating count of request timeouts.

Function
REQ-017 SHALL implement the states IDLE, WAIT_VALID, SEND_HDR, SEND_PAYLOAD and SEND_CSUM.
REQ-018 IDLE: when data_present=1, SHALL go to WAIT_VALID and assert data_request for exactly the next cycle.
REQ-019 WAIT_VALID: on data_valid=1, SHALL capture trace_element_in and if_stage_end_in into internal registers and go to SEND_HDR.
REQ-020 WAIT_VALID: if data_valid is not seen within TIMEOUT_CYCLES cycles after data_request, SHALL return to IDLE and increment timeout_count.
REQ-021 timeout_count SHALL saturate at 255.
REQ-022 data_valid SHALL be ignored in every state except WAIT_VALID.
REQ-023 Packet byte order SHALL be: HEADER_BYTE, then trace element bytes LSB first (TRACE_WIDTH/8 bytes), then if_stage_end bytes LSB first (4 bytes), then the checksum byte if it is enabled (REQ-034).
REQ-024 out_valid SHALL be high in SEND_HDR, SEND_PAYLOAD and SEND_CSUM, and low in IDLE and WAIT_VALID.
REQ-025 A byte transfers only in a cycle with out_valid=1 and out_ready=1.
REQ-026 out_data SHALL stay stable until its byte transfers.
REQ-027 The byte index counter SHALL advance only on a transfer and SHALL be wide enough for TRACE_WIDTH/8+5 bytes.
REQ-028 out_valid SHALL rise in the cycle after data_valid is captured, carrying HEADER_BYTE.
REQ-029 After the last byte transfers, SHALL enter IDLE; the earliest next data_request SHALL be one cycle after IDLE samples data_present=1.
REQ-030 The captured element SHALL NOT change until the packet completes; there is no second element in flight.

Reset
REQ-031 While rst=1: state=IDLE, data_request=0, out_valid=0, out_data=0, busy=0, timeout_count=0, byte index=0, captured registers=0, checksum accumulator=0.
REQ-032 Reset mid-packet SHALL abort the packet; out_valid SHALL be 0 from the first clock edge with rst=1, with no partial packet resumed.
REQ-033 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-034 With macro TRACE_PKT_CHECKSUM_EN defined: SEND_CSUM SHALL send one byte equal to the XOR of all payload bytes (header excluded); packet length = TRACE_WIDTH/8+6.
REQ-035 With TRACE_PKT_CHECKSUM_EN undefined: SEND_CSUM and the accumulator SHALL be absent; the packet SHALL end after the last if_stage_end byte; length = TRACE_WIDTH/8+5.

Verification
REQ-036 Bench SHALL cover basic packet (checksum on, out_ready=1): trace=64'h0123456789ABCDEF, end=32'h10 -> bytes A5 EF CD AB 89 67 45 23 01 10 00 00 00 10; same with checksum off -> identical without the final 10.
REQ-037 Bench SHALL cover backpressure: out_ready=0 for 3 cycles while byte index 5 is presented -> out_data held at 8'h67 with out_valid=1 for those cycles, then the sequence continues unchanged.
REQ-038 Bench SHALL cover timeout: data_present=1 with no data_valid -> after 8 cycles state returns to IDLE, timeout_count=1, and a new data_request pulse follows.
REQ-039 Bench SHALL cover reset mid-packet: rst=1 at byte index 3 -> out_valid=0 and timeout_count=0 the next cycle; after rst is released with data_present=1, a fresh packet starts with A5.
REQ-040 Bench SHALL cover back-to-back and spurious pulses: two elements queued -> two complete packets, with exactly one data_request per packet; a data_valid pulse while in IDLE -> no capture and no output.
